qmatvec_stream: RTL and testbench

Parametrised quantized matrix-vector engine for the quantization pipeline. It streams a Q16.16 input vector, quantizes each element to signed Q_W bits and multiply-accumulates it against LANES signed weights in parallel. It then dequantizes the LANES accumulators and emits them one per beat on a valid/ready output stream. It adds input and output backpressure, saturation, run-time-ignorable start and a last-beat marker to the fixed 4-lane, 8-element flow.

---
 rtl/qmatvec_stream.sv | 206 ++++++++++++++++++++
 tb/tb_qmatvec_stream.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/qmatvec_stream.sv
// qmatvec_stream: streaming quantized matrix-vector engine.
// Accepts VEC_LEN signed Q16.16 elements, quantizes each to Q_W bits, and MACs it against
// LANES weights in parallel. It then dequantizes each accumulator and emits one lane per beat.
// Ports:
//   clk_i, rstn_i          clock (rising edge), asynchronous active-low reset
//   start_i                start pulse, only honoured in idle
//   x_valid_i/x_ready_o    input element handshake
//   x_data_i               input element (signed fixed point)
//   w_data_i               LANES weights for this element, lane 0 in the MSBs
//   out_valid_o/ready_i    output beat handshake
//   out_last_o             marks the lane LANES-1 beat
//   dout_o                 dequantized, saturated result
//   busy_o, done_o         status; done_o pulses once after the final output handshake
module qmatvec_stream #(
   parameter int unsigned IN_W    = 32,
   parameter int unsigned Q_W     = 8,
   parameter int unsigned LANES   = 4,
   parameter int unsigned VEC_LEN = 8,
   parameter int unsigned ACC_W   = 32,
   parameter int unsigned OUT_W   = 32,
   parameter logic [31:0] QMUL_X  = 32'd2408,
   parameter logic [31:0] DEQ_MUL = 32'd134
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  start_i,
   input  logic                  x_valid_i,
   output logic                  x_ready_o,
   input  logic [IN_W-1:0]       x_data_i,
   input  logic [LANES*Q_W-1:0]  w_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic                  out_last_o,
   output logic [OUT_W-1:0]      dout_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int unsigned CNT_W  = $clog2(VEC_LEN + 1);
   localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned P_W    = IN_W + 33;
   localparam int unsigned Y_W    = ACC_W + 33;
   localparam logic [P_W-1:0] RND_HALF = P_W'(1) << 31;

   typedef enum logic [2:0] {StIdle, StAccum, StDrain, StOutput, StDone} state_e;

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     drain_q, drain_d;
   logic [LANE_W-1:0]        lane_q, lane_d;
   logic signed [Q_W-1:0]    q_q, q_d;
   logic [LANES*Q_W-1:0]     w_q, w_d;
   logic                     mac_q, mac_d;
   logic signed [ACC_W-1:0]  acc_q [LANES];
   logic signed [ACC_W-1:0]  acc_d [LANES];
   logic signed [ACC_W-1:0]  acc_mac [LANES];
   logic [OUT_W-1:0]         dout_q, dout_d;
   logic                     last_q, last_d;
   logic                     valid_q, valid_d;

   logic                     x_accept;
   logic signed [P_W-1:0]    prod, rnd;
   logic signed [IN_W:0]     q_full;
   logic signed [Q_W-1:0]    q_sat;
   logic [LANE_W-1:0]        deq_sel;
   logic signed [Y_W-1:0]    y_full;
   logic [OUT_W-1:0]         y_sat;
   logic signed [2*Q_W-1:0]  mprod [LANES];

   assign x_ready_o   = (state_q == StAccum) && (cnt_q < CNT_W'(VEC_LEN));
   assign x_accept    = x_valid_i && x_ready_o;
   assign out_valid_o = valid_q;
   assign out_last_o  = last_q;
   assign dout_o      = dout_q;
   assign busy_o      = (state_q != StIdle) && (state_q != StDone);
   assign done_o      = (state_q == StDone);

   // Quantize: round half up via +2^31 before dropping the 32 fraction bits, then clamp.
   always_comb begin
      prod   = P_W'($signed(x_data_i)) * $signed(P_W'({1'b0, QMUL_X}));
      rnd    = prod + $signed(RND_HALF);
      q_full = rnd[P_W-1:32];
      if (!q_full[IN_W] && (|q_full[IN_W-1:Q_W-1])) begin
         q_sat = {1'b0, {(Q_W-1){1'b1}}};
      end else if (q_full[IN_W] && !(&q_full[IN_W-1:Q_W-1])) begin
         q_sat = {1'b1, {(Q_W-1){1'b0}}};
      end else begin
         q_sat = q_full[Q_W-1:0];
      end
   end

   // One shared dequantizer: lane 0 while draining, otherwise the lane after the current beat.
   always_comb begin
      deq_sel = '0;
      if (state_q == StOutput && lane_q != LANE_W'(LANES - 1)) begin
         deq_sel = lane_q + LANE_W'(1);
      end
      y_full = Y_W'(acc_q[deq_sel]) * $signed(Y_W'({1'b0, DEQ_MUL}));
      if (!y_full[Y_W-1] && (|y_full[Y_W-2:OUT_W-1])) begin
         y_sat = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (y_full[Y_W-1] && !(&y_full[Y_W-2:OUT_W-1])) begin
         y_sat = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         y_sat = y_full[OUT_W-1:0];
      end
   end

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         mprod[k]   = (2*Q_W)'(q_q) * $signed((2*Q_W)'($signed(w_q[LANES*Q_W-1-k*Q_W -: Q_W])));
         acc_mac[k] = acc_q[k] + ACC_W'(mprod[k]);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drain_d = drain_q;
      lane_d  = lane_q;
      q_d     = q_q;
      w_d     = w_q;
      mac_d   = 1'b0;
      acc_d   = acc_q;
      dout_d  = dout_q;
      last_d  = last_q;
      valid_d = valid_q;
      // The final MAC lands during the first drain cycle.
      if (mac_q) acc_d = acc_mac;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               for (int k = 0; k < LANES; k++) acc_d[k] = '0;
               cnt_d   = '0;
               state_d = StAccum;
            end
         end
         StAccum: begin
            if (x_accept) begin
               q_d   = q_sat;
               w_d   = w_data_i;
               mac_d = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(VEC_LEN - 1)) begin
                  state_d = StDrain;
                  drain_d = 1'b0;
               end
            end
         end
         StDrain: begin
            if (!drain_q) begin
               drain_d = 1'b1;
            end else begin
               state_d = StOutput;
               lane_d  = '0;
               dout_d  = y_sat;
               last_d  = (LANES == 1);
               valid_d = 1'b1;
            end
         end
         StOutput: begin
            if (out_ready_i) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  state_d = StDone;
               end else begin
                  lane_d = lane_q + LANE_W'(1);
                  dout_d = y_sat;
                  last_d = ((lane_q + LANE_W'(1)) == LANE_W'(LANES - 1));
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         drain_q <= 1'b0;
         lane_q  <= '0;
         q_q     <= '0;
         w_q     <= '0;
         mac_q   <= 1'b0;
         for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
         dout_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
         lane_q  <= lane_d;
         q_q     <= q_d;
         w_q     <= w_d;
         mac_q   <= mac_d;
         acc_q   <= acc_d;
         dout_q  <= dout_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_qmatvec_stream.sv
// tb_qmatvec_stream: directed, scoreboard-based bench for qmatvec_stream.
// Two instances share all inputs: one with unity Q16.16 multipliers, one with a maximal
// dequantization multiplier to exercise output saturation.
module tb_qmatvec_stream;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        start = 1'b0;
   logic        x_valid = 1'b0;
   logic [31:0] x_data = '0;
   logic [31:0] w_data = '0;
   logic        out_ready = 1'b1;

   logic        x_ready_m, out_valid_m, last_m, busy_m, done_m;
   logic [31:0] dout_m;
   logic        x_ready_s, out_valid_s, last_s, busy_s, done_s;
   logic [31:0] dout_s;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic [31:0] m;
      logic [31:0] s;
      logic        last;
   } exp_t;
   exp_t sb[$];

   logic [31:0]       xs [8];
   logic signed [7:0] ws [8][4];

   always #5 clk = ~clk;

   qmatvec_stream #(
      .IN_W(32), .Q_W(8), .LANES(4), .VEC_LEN(8), .ACC_W(32), .OUT_W(32),
      .QMUL_X(32'h0001_0000), .DEQ_MUL(32'h0001_0000)
   ) dut_m (
      .clk_i(clk), .rstn_i(rstn), .start_i(start), .x_valid_i(x_valid), .x_ready_o(x_ready_m),
      .x_data_i(x_data), .w_data_i(w_data), .out_valid_o(out_valid_m), .out_ready_i(out_ready),
      .out_last_o(last_m), .dout_o(dout_m), .busy_o(busy_m), .done_o(done_m)
   );

   qmatvec_stream #(
      .IN_W(32), .Q_W(8), .LANES(4), .VEC_LEN(8), .ACC_W(32), .OUT_W(32),
      .QMUL_X(32'h0001_0000), .DEQ_MUL(32'hFFFF_FFFF)
   ) dut_s (
      .clk_i(clk), .rstn_i(rstn), .start_i(start), .x_valid_i(x_valid), .x_ready_o(x_ready_s),
      .x_data_i(x_data), .w_data_i(w_data), .out_valid_o(out_valid_s), .out_ready_i(out_ready),
      .out_last_o(last_s), .dout_o(dout_s), .busy_o(busy_s), .done_o(done_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic longint quant(input logic signed [31:0] x);
      longint p, q;
      p = longint'(x) * 64'sd65536;
      q = (p + 64'sd2147483648) >>> 32;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      return q;
   endfunction

   function automatic logic [31:0] deq(input longint acc, input longint mul);
      longint y;
      y = acc * mul;
      if (y > 64'sd2147483647) y = 64'sd2147483647;
      if (y < -64'sd2147483648) y = -64'sd2147483648;
      return y[31:0];
   endfunction

   task automatic push_expected();
      longint a;
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         a = 0;
         for (int n = 0; n < 8; n++) a += quant(xs[n]) * longint'(ws[n][k]);
         e.m    = deq(a, 64'sd65536);
         e.s    = deq(a, 64'sd4294967295);
         e.last = (k == 3);
         sb.push_back(e);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("busy_after_start", {31'b0, busy_m}, 32'd1);
   endtask

   // Feed n elements of xs/ws; returns the number accepted.
   task automatic feed(input int n, input bit toggle, input bit start_mid, output int got);
      int cyc;
      logic acc;
      got = 0;
      cyc = 0;
      while (got < n && cyc < 200) begin
         x_valid = toggle ? (cyc % 2 == 0) : 1'b1;
         x_data  = xs[got];
         w_data  = {ws[got][0], ws[got][1], ws[got][2], ws[got][3]};
         start   = start_mid && (got == 3);
         @(negedge clk);
         acc = x_valid && x_ready_m;
         @(posedge clk); #1;
         if (acc) got++;
         cyc++;
      end
      x_valid = 1'b0;
      start   = 1'b0;
   endtask

   task automatic run_vec(input bit toggle, input int stall_beat, input bit start_mid);
      int got, beats, cyc, stall;
      bit seen;
      logic [31:0] held;
      exp_t e;
      pulse_start();
      feed(8, toggle, start_mid, got);
      if (got < 8) chk("accept_timeout", got, 8);
      push_expected();
      beats = 0; cyc = 1; stall = 0; seen = 0; held = '0;
      while (beats < 4 && cyc < 200) begin
         out_ready = !(beats == stall_beat && stall < 5);
         start = start_mid && (beats == 1);
         @(negedge clk);
         if (cyc == 1) chk("x_ready_low_after_last", {31'b0, x_ready_m}, 32'd0);
         if (out_valid_m && !seen) begin
            seen = 1;
            chk("first_valid_latency", cyc, 3);
         end
         if (out_valid_m && !out_ready) begin
            if (stall == 0) held = dout_m;
            else chk("stall_stable", dout_m, held);
            stall++;
         end
         if (out_valid_m && out_ready) begin
            e = sb.pop_front();
            chk("dout", dout_m, e.m);
            chk("dout_sat", dout_s, e.s);
            chk("last", {31'b0, last_m}, {31'b0, e.last});
            beats++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b1;
      start = start_mid;
      if (beats < 4) chk("output_timeout", beats, 4);
      chk("done_pulse", {31'b0, done_m}, 32'd1);
      chk("busy_in_done", {31'b0, busy_m}, 32'd0);
      chk("valid_in_done", {31'b0, out_valid_m}, 32'd0);
      @(posedge clk); #1 start = 1'b0;
      chk("done_one_cycle", {31'b0, done_m}, 32'd0);
      chk("idle_after_done", {31'b0, busy_m}, 32'd0);
   endtask

   task automatic set_single(input logic [31:0] x);
      for (int n = 0; n < 8; n++) begin
         xs[n] = (n == 0) ? x : 32'd0;
         for (int k = 0; k < 4; k++) ws[n][k] = 8'sd1;
      end
   endtask

   task automatic set_full();
      for (int n = 0; n < 8; n++) begin
         xs[n] = 32'h0002_0000;
         ws[n][0] = 8'sd1; ws[n][1] = -8'sd1; ws[n][2] = 8'sd127; ws[n][3] = 8'sd0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_x_ready"}, {31'b0, x_ready_m | x_ready_s}, 32'd0);
      chk({tag, "_valid"}, {31'b0, out_valid_m | out_valid_s}, 32'd0);
      chk({tag, "_last"}, {31'b0, last_m | last_s}, 32'd0);
      chk({tag, "_dout"}, dout_m | dout_s, 32'd0);
      chk({tag, "_busy"}, {31'b0, busy_m | busy_s}, 32'd0);
      chk({tag, "_done"}, {31'b0, done_m | done_s}, 32'd0);
   endtask

   initial begin
      int got;
      #1 rstn = 1'b0;
      #1 check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      // Rounding and quantizer saturation through lane sums of one nonzero element.
      set_single(32'h0003_8000);  run_vec(0, -1, 0);
      set_single(32'hFFFD_8000);  run_vec(0, -1, 0);
      set_single(32'h00C8_0000);  run_vec(0, -1, 0);
      set_single(32'hFED4_0000);  run_vec(0, -1, 0);

      // Full vector, then with input gaps and an output stall on the second beat.
      set_full();  run_vec(0, -1, 0);
      set_full();  run_vec(1, 1, 0);

      // Start pulses in ACCUM, OUTPUT and DONE must be ignored.
      set_full();  run_vec(0, -1, 1);

      // Abort mid-run with an asynchronous reset.
      for (int n = 0; n < 8; n++) begin
         xs[n] = 32'(n + 1) << 15;
         for (int k = 0; k < 4; k++) ws[n][k] = 8'(n * 3 - k * 5);
      end
      pulse_start();
      feed(3, 0, 0, got);
      chk("pre_reset_accepts", got, 3);
      #2 rstn = 1'b0;
      #1 check_all_zero("midrun_reset");
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("no_done_after_abort", {31'b0, done_m}, 32'd0);
      end
      run_vec(0, -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
